// File: rtl/lfsr_pkg.sv
// lfsr_pkg: definitions shared by the 4-bit LFSR stage and its downstream
// checker.
//   LFSR_W     - LFSR state width
//   state_t    - checker FSM states
//   lfsr_next  - LFSR next-state function (shift left, feedback s[3]^s[2])
package lfsr_pkg;

  localparam int LFSR_W = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Period-15 sequence: 0001 -> 0010 -> 0100 -> 1001 -> 0011 -> ... -> 1000 -> 0001
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

endpackage

// File: rtl/lfsr_seq_checker_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clock  - clock, posedge
//   reset  - synchronous active-high reset, count -> 0
//   inc    - add one (holds at all-ones)
//   clr    - clear; clr together with inc loads 1 so the coincident event
//            is not lost
//   count  - current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= inc ? W'(1) : '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: receive/check half of the pseudo-random BIST path.
// Seeds a local predictor from the first non-zero LFSR sample, declares lock
// after LOCK_CNT consecutive correct predictions, then flywheels the
// predictor and counts mispredictions.
//   clock      - clock, posedge
//   reset      - synchronous active-high reset
//   in_valid   - in_data carries a new LFSR sample
//   in_data    - LFSR state sample
//   clear_cnt  - synchronous clear of err_count
//   locked     - registered, high while in LOCKED
//   err_pulse  - registered, one cycle per misprediction while LOCKED
//   err_count  - saturating misprediction count
//   zero_seen  - sticky, an all-zero sample was received (reset clears)
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2,
  parameter int ERR_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  input  logic              clear_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic              zero_seen
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);

  state_t            state_reg;
  logic [LFSR_W-1:0] pred_reg;
  logic [MW-1:0]     match_cnt_reg;
  logic [UW-1:0]     miss_cnt_reg;
  logic              locked_reg;
  logic              err_pulse_reg;
  logic              zero_seen_reg;
  logic              err_now;

  // Misprediction while locked; a zero sample never equals a (non-zero)
  // prediction, so it is counted here as well.
  assign err_now = in_valid && (state_reg == LOCKED) && (in_data != pred_reg);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= SEARCH;
      pred_reg      <= '0;
      match_cnt_reg <= '0;
      miss_cnt_reg  <= '0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      zero_seen_reg <= 1'b0;
    end else begin
      err_pulse_reg <= 1'b0;
      if (in_valid) begin
        if (in_data == '0) begin
          zero_seen_reg <= 1'b1;
        end
        case (state_reg)
          SEARCH: begin
            if (in_data != '0) begin
              pred_reg      <= lfsr_next(in_data);
              match_cnt_reg <= '0;
              state_reg     <= ACQUIRE;
            end
          end
          ACQUIRE: begin
            if (in_data == '0) begin
              state_reg <= SEARCH;
            end else if (in_data == pred_reg) begin
              pred_reg      <= lfsr_next(in_data);
              match_cnt_reg <= match_cnt_reg + MW'(1);
              if (match_cnt_reg == MW'(LOCK_CNT - 1)) begin
                state_reg    <= LOCKED;
                locked_reg   <= 1'b1;
                miss_cnt_reg <= '0;
              end
            end else begin
              // Reseed on any non-zero mismatch while acquiring.
              pred_reg      <= lfsr_next(in_data);
              match_cnt_reg <= '0;
            end
          end
          LOCKED: begin
            // Flywheel: the prediction advances regardless of the sample.
            pred_reg <= lfsr_next(pred_reg);
            if (in_data == pred_reg) begin
              miss_cnt_reg <= '0;
            end else begin
              err_pulse_reg <= 1'b1;
              miss_cnt_reg  <= miss_cnt_reg + UW'(1);
              if (miss_cnt_reg == UW'(UNLOCK_CNT - 1)) begin
                state_reg  <= SEARCH;
                locked_reg <= 1'b0;
              end
            end
          end
          default: begin
            state_reg  <= SEARCH;
            locked_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (err_now),
    .clr   (clear_cnt),
    .count (err_count)
  );

  assign locked    = locked_reg;
  assign err_pulse = err_pulse_reg;
  assign zero_seen = zero_seen_reg;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
module tb_lfsr_seq_checker;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        clear_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        zero_seen;

  // Second instance with a 2-bit error counter for the saturation case.
  logic        in_valid2;
  logic [3:0]  in_data2;
  logic        clear_cnt2;
  logic        locked2;
  logic        err_pulse2;
  logic [1:0]  err_count2;
  logic        zero_seen2;

  int n_cmp;
  int n_bad;

  lfsr_seq_checker #(.LOCK_CNT(3), .UNLOCK_CNT(2), .ERR_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .zero_seen (zero_seen)
  );

  lfsr_seq_checker #(.LOCK_CNT(3), .UNLOCK_CNT(2), .ERR_W(2)) dut2 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid2),
    .in_data   (in_data2),
    .clear_cnt (clear_cnt2),
    .locked    (locked2),
    .err_pulse (err_pulse2),
    .err_count (err_count2),
    .zero_seen (zero_seen2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply one cycle of stimulus to dut and sample #1 after the edge.
  task automatic step(input logic v, input logic [3:0] d, input logic c);
    in_valid  = v;
    in_data   = d;
    clear_cnt = c;
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    clear_cnt = 1'b0;
  endtask

  task automatic step2(input logic v, input logic [3:0] d, input logic c);
    in_valid2  = v;
    in_data2   = d;
    clear_cnt2 = c;
    @(posedge clock);
    #1;
    in_valid2  = 1'b0;
    clear_cnt2 = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++;
    if ({locked, err_pulse, err_count, zero_seen} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset: locked=%0b err_pulse=%0b err_count=%0d zero_seen=%0b required all 0",
               locked, err_pulse, err_count, zero_seen);
    end
    n_cmp++;
    if ({locked2, err_pulse2, err_count2, zero_seen2} !== 5'd0) begin
      n_bad++;
      $display("FAIL reset2: locked=%0b err_pulse=%0b err_count=%0d zero_seen=%0b required all 0",
               locked2, err_pulse2, err_count2, zero_seen2);
    end
    $display("reset: locked=%0b err_count=%0d zero_seen=%0b", locked, err_count, zero_seen);
  endtask

  // Seed 0001 then three matches; locked rises only after 1001.
  task automatic test_lock;
    logic [3:0] seq [4];
    logic       exp_lock [4];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1001};
    exp_lock = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq[i], 1'b0);
      $display("lock: in=%b locked=%0b err_pulse=%0b err_count=%0d", seq[i], locked, err_pulse, err_count);
      n_cmp++;
      if (locked !== exp_lock[i] || err_pulse !== 1'b0 || err_count !== 16'd0) begin
        n_bad++;
        $display("FAIL lock[%0d]: locked=%0b err_pulse=%0b err_count=%0d required locked=%0b 0 0",
                 i, locked, err_pulse, err_count, exp_lock[i]);
      end
    end
  endtask

  // Locked with pred=0011: zero sample is one error, then 0110 matches.
  task automatic test_zero_in_lock;
    step(1'b1, 4'b0000, 1'b0);
    $display("zero_in_lock: in=0000 locked=%0b err_pulse=%0b err_count=%0d zero_seen=%0b",
             locked, err_pulse, err_count, zero_seen);
    n_cmp++;
    if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1 || zero_seen !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_in_lock: err_pulse=%0b err_count=%0d locked=%0b zero_seen=%0b required 1 1 1 1",
               err_pulse, err_count, locked, zero_seen);
    end
    step(1'b1, 4'b0110, 1'b0);
    $display("zero_in_lock: in=0110 locked=%0b err_pulse=%0b err_count=%0d", locked, err_pulse, err_count);
    n_cmp++;
    if (err_pulse !== 1'b0 || err_count !== 16'd1 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_recover: err_pulse=%0b err_count=%0d locked=%0b required 0 1 1",
               err_pulse, err_count, locked);
    end
  endtask

  // Gap of 5 invalid cycles with garbage; then the expected 1101.
  task automatic test_gap;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'(i * 3 + 5), 1'b0);
      n_cmp++;
      if (err_pulse !== 1'b0 || locked !== 1'b1) begin
        n_bad++;
        $display("FAIL gap[%0d]: err_pulse=%0b locked=%0b required 0 1", i, err_pulse, locked);
      end
    end
    step(1'b1, 4'b1101, 1'b0);
    $display("gap: resume in=1101 locked=%0b err_pulse=%0b err_count=%0d", locked, err_pulse, err_count);
    n_cmp++;
    if (err_pulse !== 1'b0 || locked !== 1'b1 || err_count !== 16'd1) begin
      n_bad++;
      $display("FAIL gap_resume: err_pulse=%0b locked=%0b err_count=%0d required 0 1 1",
               err_pulse, locked, err_count);
    end
  endtask

  // Fresh lock, then two wrong samples unlock; 0001 restarts acquisition.
  task automatic test_unlock;
    logic [3:0] seq [4];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1001};
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, seq[i], 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    $display("unlock: in=1111 locked=%0b err_pulse=%0b err_count=%0d", locked, err_pulse, err_count);
    n_cmp++;
    if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL unlock_miss1: err_pulse=%0b err_count=%0d locked=%0b required 1 1 1",
               err_pulse, err_count, locked);
    end
    step(1'b1, 4'b1111, 1'b0);
    $display("unlock: in=1111 locked=%0b err_pulse=%0b err_count=%0d", locked, err_pulse, err_count);
    n_cmp++;
    if (err_pulse !== 1'b1 || err_count !== 16'd2 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL unlock_miss2: err_pulse=%0b err_count=%0d locked=%0b required 1 2 0",
               err_pulse, err_count, locked);
    end
    // Back-to-back restart: no errors counted outside LOCKED.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq[i], 1'b0);
      n_cmp++;
      if (locked !== (i == 3) || err_pulse !== 1'b0 || err_count !== 16'd2) begin
        n_bad++;
        $display("FAIL relock[%0d]: locked=%0b err_pulse=%0b err_count=%0d required %0b 0 2",
                 i, locked, err_pulse, err_count, (i == 3));
      end
    end
    $display("unlock: relocked locked=%0b err_count=%0d", locked, err_count);
  endtask

  // Acquire reseeds on a non-zero mismatch instead of going back to SEARCH.
  task automatic test_reseed;
    logic [3:0] seq [5];
    logic       exp_lock [5];
    seq = '{4'b0001, 4'b0111, 4'b1111, 4'b1110, 4'b1100};
    exp_lock = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[i], 1'b0);
      n_cmp++;
      if (locked !== exp_lock[i] || err_pulse !== 1'b0) begin
        n_bad++;
        $display("FAIL reseed[%0d]: locked=%0b err_pulse=%0b required %0b 0", i, locked, err_pulse, exp_lock[i]);
      end
    end
    $display("reseed: locked=%0b err_count=%0d", locked, err_count);
  endtask

  // Twenty zero samples: never leaves SEARCH, zero_seen set.
  task automatic test_zeros;
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 4'b0000, 1'b0);
    $display("zeros: locked=%0b err_count=%0d zero_seen=%0b", locked, err_count, zero_seen);
    n_cmp++;
    if (locked !== 1'b0 || err_count !== 16'd0 || zero_seen !== 1'b1 || err_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL zeros: locked=%0b err_count=%0d zero_seen=%0b err_pulse=%0b required 0 0 1 0",
               locked, err_count, zero_seen, err_pulse);
    end
    // A proper sequence afterwards must still lock (SEARCH was held).
    step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b0010, 1'b0);
    step(1'b1, 4'b0100, 1'b0);
    step(1'b1, 4'b1001, 1'b0);
    n_cmp++;
    if (locked !== 1'b1 || zero_seen !== 1'b1) begin
      n_bad++;
      $display("FAIL zeros_then_lock: locked=%0b zero_seen=%0b required 1 1", locked, zero_seen);
    end
  endtask

  // ERR_W=2: alternating bad/good after lock saturates at 3, then clears.
  task automatic test_saturate;
    logic [3:0] seq [4];
    logic [3:0] stim [9];
    logic [1:0] exp_cnt [9];
    logic       exp_pulse [9];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1001};
    // Expected stream after lock: 0011 0110 1101 1010 0101 1011 0111 1111 1110
    stim      = '{4'b0000, 4'b0110, 4'b0000, 4'b1010, 4'b0000, 4'b1011, 4'b0000, 4'b1111, 4'b0000};
    exp_cnt   = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    exp_pulse = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) step2(1'b1, seq[i], 1'b0);
    n_cmp++;
    if (locked2 !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_lock: locked=%0b required 1", locked2);
    end
    for (int i = 0; i < 9; i++) begin
      step2(1'b1, stim[i], 1'b0);
      $display("saturate: in=%b err_pulse=%0b err_count=%0d locked=%0b", stim[i], err_pulse2, err_count2, locked2);
      n_cmp++;
      if (err_count2 !== exp_cnt[i] || err_pulse2 !== exp_pulse[i] || locked2 !== 1'b1) begin
        n_bad++;
        $display("FAIL sat[%0d]: err_count=%0d err_pulse=%0b locked=%0b required %0d %0b 1",
                 i, err_count2, err_pulse2, locked2, exp_cnt[i], exp_pulse[i]);
      end
    end
    // Next expected 1100: mismatch coincident with clear.
    step2(1'b1, 4'b0000, 1'b1);
    $display("saturate: clear+miss err_count=%0d", err_count2);
    n_cmp++;
    if (err_count2 !== 2'd1 || err_pulse2 !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_with_err: err_count=%0d err_pulse=%0b required 1 1", err_count2, err_pulse2);
    end
    // Next expected 1000: match with clear.
    step2(1'b1, 4'b1000, 1'b1);
    $display("saturate: clear alone err_count=%0d", err_count2);
    n_cmp++;
    if (err_count2 !== 2'd0 || err_pulse2 !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_alone: err_count=%0d err_pulse=%0b required 0 0", err_count2, err_pulse2);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 4'd0;
    clear_cnt  = 1'b0;
    in_valid2  = 1'b0;
    in_data2   = 4'd0;
    clear_cnt2 = 1'b0;
    #2;
    test_reset();
    test_lock();
    test_zero_in_lock();
    test_gap();
    test_unlock();
    test_reseed();
    test_zeros();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_checker.md
# lfsr_seq_checker

Downstream consumer of the 4-bit LFSR stage. It samples the LFSR's `count` output on qualifying cycles and self-synchronises to the sequence by seeding a local predictor from the first non-zero sample. It then tracks the stream, declares lock, and counts mismatches. It is the receive/check half of the pseudo-random BIST path.

## Interface
Parameters:
- LOCK_CNT, 3: consecutive correct predictions needed to enter LOCKED (≥1).
- UNLOCK_CNT, 2: consecutive mispredictions in LOCKED that force a return to SEARCH (≥1).
- ERR_W, 16: width of the saturating error counter.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  in_data is a new LFSR sample this cycle.
- in_data  in  4  LFSR state sample.
- clear_cnt  in  1  synchronous clear of err_count.
- locked  out  1  registered; high while in LOCKED.
- err_pulse  out  1  registered; one-cycle pulse per misprediction while LOCKED.
- err_count  out  ERR_W  saturating count of mispredictions in LOCKED.
- zero_seen  out  1  sticky; an all-zero sample was received. Cleared by reset only.

## Operation
- Next-state function: nxt(s) = {s[2:0], s[3]^s[2]}. This gives the period-15 sequence 0001→0010→0100→1001→0011→0110→1101→1010→0101→1011→0111→1111→1110→1100→1000→0001.
- Internal state: FSM, 4-bit pred, match_cnt, miss_cnt.
- in_valid=0: nothing changes (FSM, pred, counters all hold) except clear_cnt handling.
- SEARCH:
  - Valid non-zero sample: pred←nxt(in_data), match_cnt←0, go to ACQUIRE.
  - Valid zero sample: stay in SEARCH, set zero_seen.
- ACQUIRE:
  - Valid sample == pred: pred←nxt(in_data), match_cnt++. On the LOCK_CNT-th match go to LOCKED with miss_cnt←0.
  - Valid non-zero mismatch: reseed with pred←nxt(in_data), match_cnt←0, stay in ACQUIRE.
  - Valid zero sample: go to SEARCH, set zero_seen.
  - No errors are counted in ACQUIRE.
- LOCKED (flywheel):
  - pred←nxt(pred) on every valid sample, independent of in_data.
  - Match: miss_cnt←0.
  - Mismatch: err_pulse, err_count+1 (saturating at all-ones), miss_cnt++. On the UNLOCK_CNT-th consecutive miss go to SEARCH.
  - A zero sample is a mismatch and also sets zero_seen.
- err_count update rules:
  - clear_cnt with no error that cycle: err_count←0.
  - clear_cnt with an error that cycle: err_count←1.
- Reset: FSM=SEARCH; pred, match_cnt, miss_cnt = 0; locked=0, err_pulse=0, err_count=0, zero_seen=0.
- Reset mid-operation discards lock immediately. No partial state survives.

## Timing
- Sample at edge k → FSM, pred and outputs update at edge k; they are visible during cycle k+1.
- Lock latency: 1 seed sample + LOCK_CNT matching valid samples. locked rises the cycle after the LOCK_CNT-th match.
- err_pulse is high exactly the cycle after the offending sample, including on the sample that causes unlock.
- locked falls in the same cycle as the final err_pulse.
- Back-to-back valid samples are supported at full rate. Gaps of any length are transparent.
- No combinational path from any input to any output.

## Structure
- Shared package lfsr_pkg:
  - LFSR_W=4.
  - lfsr_next function (the nxt above). The existing LFSR stage should converge on the same function.
  - FSM state enum {SEARCH, ACQUIRE, LOCKED}.
- Sub-module sat_counter holds err_count. It has parameter W and inputs inc and clr, with clr+inc giving 1.
- The FSM and predictor stay in the top module.

## Test plan
- Reset, then feed valid 0001,0010,0100,1001 (LOCK_CNT=3) → locked=1 one cycle after the 1001 sample; err_count=0; err_pulse never high.
- Locked with pred=0011, feed 0000 then 0110 → err_pulse one cycle, err_count=1, locked stays 1, zero_seen=1.
- Locked, feed two consecutive wrong values (1111,1111 where 0011,0110 expected) → two err_pulses, err_count=2, locked=0 with the second pulse. Next sample 0001 restarts ACQUIRE.
- Locked, deassert in_valid for 5 cycles with garbage on in_data, then resume with the correct next value → no err_pulse, locked held.
- Reset, then 20 valid 0000 samples → state stays SEARCH, locked=0, err_count=0, zero_seen=1.
- ERR_W=2, locked, inject 5 mismatches separated by matches → err_count saturates at 3. clear_cnt coincident with a mismatch → err_count=1. clear_cnt alone → 0.
